// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style control unit for a multicycle MIPS-like datapath. It sequences
// fetch / decode / execute / memory / write-back states and decodes all control
// outputs from the current state and the opcode latched in DECODE.
//
// Parameters
//   ALUOP_WIDTH  width of ALUOp (>=3); function code sits in [2:0], rest zero
//   MEM_WAIT     1: memory states stall on mem_ready, 0: mem_ready ignored
//   CNT_WIDTH    width of the retired-instruction counter
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   OP               opcode from the instruction register (valid from DECODE)
//   mem_ready        memory completes the current access this cycle
//   PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite  enables
//   IorD, RegDst, MemtoReg, ALUSrcA, BranchType (1 beq / 0 bne)  mux selects
//   ALUSrcB, PCSource  2-bit mux selects
//   ALUOp            ALU function code
//   illegal_op       one-cycle pulse while in the ILLEGAL state
//   state_o          current state encoding
//   retired_cnt      count of completed instructions (wraps)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module multicycle_control #(
    parameter int unsigned ALUOP_WIDTH = 3,
    parameter int unsigned MEM_WAIT    = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IRWrite,
    output logic                   RegWrite,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IorD,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   ALUSrcA,
    output logic                   BranchType,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   illegal_op,
    output logic [3:0]             state_o,
    output logic [CNT_WIDTH-1:0]   retired_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_LUI = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_R   = 3'b111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        ILLEGAL  = 4'd11
    } stateT;

    stateT      state;
    stateT      stateNext;
    logic [5:0] opQ;
    logic [2:0] aluCode;
    logic       ready;
    logic       retire;

    // With MEM_WAIT=0 every memory access is treated as completing at once.
    assign ready = mem_ready | (MEM_WAIT == 0);

    // An instruction retires on the edge that returns it to FETCH; ILLEGAL does not count.
    assign retire = (state == WB_ALU) || (state == WB_MEM) || (state == BRANCH) ||
                    (state == JUMP)   || ((state == MEM_WR) && ready);

    // State, latched opcode and retirement counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            opQ         <= 6'h00;
            retired_cnt <= '0;
        end else begin
            state <= stateNext;
            if (state == DECODE) begin
                opQ <= OP;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state logic; DECODE dispatches on the live OP since opQ loads on the same edge.
    always_comb begin
        stateNext = FETCH;
        case (state)
            FETCH:    stateNext = ready ? DECODE : FETCH;
            DECODE: begin
                case (OP)
                    OP_RTYPE:                         stateNext = EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: stateNext = EXEC_I;
                    OP_LW, OP_SW:                     stateNext = MEM_ADDR;
                    OP_BEQ, OP_BNE:                   stateNext = BRANCH;
                    OP_J:                             stateNext = JUMP;
                    default:                          stateNext = ILLEGAL;
                endcase
            end
            EXEC_R:   stateNext = WB_ALU;
            EXEC_I:   stateNext = WB_ALU;
            WB_ALU:   stateNext = FETCH;
            MEM_ADDR: stateNext = (opQ == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   stateNext = ready ? WB_MEM : MEM_RD;
            MEM_WR:   stateNext = ready ? FETCH : MEM_WR;
            WB_MEM:   stateNext = FETCH;
            BRANCH:   stateNext = FETCH;
            JUMP:     stateNext = FETCH;
            ILLEGAL:  stateNext = FETCH;
            default:  stateNext = FETCH;
        endcase
    end

    // Moore output decode from state and opQ (FETCH also qualifies IR/PC writes by ready).
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        BranchType  = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        aluCode     = ALU_LUI;
        illegal_op  = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                aluCode = ALU_ADD;
                IRWrite = ready;
                PCWrite = ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                aluCode = ALU_ADD;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                aluCode = ALU_R;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opQ)
                    OP_ORI:  aluCode = ALU_OR;
                    OP_ANDI: aluCode = ALU_AND;
                    OP_LUI:  aluCode = ALU_LUI;
                    default: aluCode = ALU_ADD;
                endcase
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = (opQ == OP_RTYPE);
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                aluCode = ALU_ADD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                aluCode     = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchType  = (opQ == OP_BEQ);
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
        // Reset forces state to FETCH, whose IR/PC writes would otherwise follow ready.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
        end
    end

    assign ALUOp   = ALUOP_WIDTH'(aluCode);
    assign state_o = 4'(state);

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps

module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: wide ALUOp (upper bit must stay 0), 2-bit counter to show wrap.
    logic       reset, memReady;
    logic [5:0] OP;
    logic PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite;
    logic IorD, RegDst, MemtoReg, ALUSrcA, BranchType, illegalOp;
    logic [1:0] ALUSrcB, PCSource, retiredCnt;
    logic [3:0] ALUOp, stateO;

    multicycle_control #(.ALUOP_WIDTH(4), .MEM_WAIT(1), .CNT_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .OP(OP), .mem_ready(memReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .BranchType(BranchType), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .illegal_op(illegalOp), .state_o(stateO),
        .retired_cnt(retiredCnt)
    );

    // Second instance: memory never ready but waiting disabled.
    logic        reset2;
    logic [5:0]  op2;
    logic        memReady2;
    logic PCWrite2, PCWriteCond2, IRWrite2, RegWrite2, MemRead2, MemWrite2;
    logic IorD2, RegDst2, MemtoReg2, ALUSrcA2, BranchType2, illegalOp2;
    logic [1:0]  ALUSrcB2, PCSource2;
    logic [2:0]  ALUOp2;
    logic [3:0]  stateO2;
    logic [15:0] retiredCnt2;

    multicycle_control #(.ALUOP_WIDTH(3), .MEM_WAIT(0), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset2), .OP(op2), .mem_ready(memReady2),
        .PCWrite(PCWrite2), .PCWriteCond(PCWriteCond2), .IRWrite(IRWrite2),
        .RegWrite(RegWrite2), .MemRead(MemRead2), .MemWrite(MemWrite2),
        .IorD(IorD2), .RegDst(RegDst2), .MemtoReg(MemtoReg2), .ALUSrcA(ALUSrcA2),
        .BranchType(BranchType2), .ALUSrcB(ALUSrcB2), .PCSource(PCSource2),
        .ALUOp(ALUOp2), .illegal_op(illegalOp2), .state_o(stateO2),
        .retired_cnt(retiredCnt2)
    );

    logic [18:0] ctrlObs;
    assign ctrlObs = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite,
                      IorD, RegDst, MemtoReg, ALUSrcA, BranchType,
                      ALUSrcB, PCSource, ALUOp};

    typedef struct packed {
        logic [3:0]  st;
        logic [5:0]  op;
        logic        rdy;
        logic [18:0] ctrl;
        logic        ill;
        logic [1:0]  cnt;
    } cycleT;

    cycleT      sb[$];
    int         checks = 0;
    int         passes = 0;
    logic [1:0] cntModel = 2'd0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference control table, written from the state descriptions.
    function automatic logic [18:0] ctrlOf(input logic [3:0] st, input logic [5:0] op,
                                           input logic rdy);
        logic pcw, pcwc, irw, rw, mr, mw, iord, rd, m2r, asa, bt;
        logic [1:0] asb, pcs;
        logic [3:0] alu;
        {pcw, pcwc, irw, rw, mr, mw, iord, rd, m2r, asa, bt} = 11'b0;
        asb = 2'b00; pcs = 2'b00; alu = 4'b0000;
        case (st)
            4'd0:  begin mr = 1'b1; asb = 2'b01; alu = 4'b0100; irw = rdy; pcw = rdy; end
            4'd1:  begin asb = 2'b11; alu = 4'b0100; end
            4'd2:  begin asa = 1'b1; alu = 4'b0111; end
            4'd3:  begin
                asa = 1'b1; asb = 2'b10;
                alu = (op == 6'h0D) ? 4'b0101 : (op == 6'h0C) ? 4'b0110 :
                      (op == 6'h0F) ? 4'b0000 : 4'b0100;
            end
            4'd4:  begin rw = 1'b1; rd = (op == 6'h00); end
            4'd5:  begin asa = 1'b1; asb = 2'b10; alu = 4'b0100; end
            4'd6:  begin mr = 1'b1; iord = 1'b1; end
            4'd7:  begin mw = 1'b1; iord = 1'b1; end
            4'd8:  begin rw = 1'b1; m2r = 1'b1; end
            4'd9:  begin asa = 1'b1; alu = 4'b0001; pcwc = 1'b1; pcs = 2'b01; bt = (op == 6'h04); end
            4'd10: begin pcw = 1'b1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, irw, rw, mr, mw, iord, rd, m2r, asa, bt, asb, pcs, alu};
    endfunction

    task automatic pushCycle(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        cycleT e;
        e.st = st; e.op = op; e.rdy = rdy;
        e.ctrl = ctrlOf(st, op, rdy);
        e.ill = (st == 4'd11);
        e.cnt = cntModel;
        sb.push_back(e);
    endtask

    // Queue the expected per-cycle trace of one instruction.
    task automatic pushInstr(input logic [5:0] op, input int fetchWaits, input int memWaits);
        logic retires = 1'b1;
        for (int i = 0; i < fetchWaits; i++) pushCycle(4'd0, op, 1'b0);
        pushCycle(4'd0, op, 1'b1);
        pushCycle(4'd1, op, 1'($urandom_range(0, 1)));
        case (op)
            6'h00: begin pushCycle(4'd2, op, 1'b1); pushCycle(4'd4, op, 1'b0); end
            6'h08, 6'h0D, 6'h0C, 6'h0F: begin
                pushCycle(4'd3, op, 1'b0); pushCycle(4'd4, op, 1'b1);
            end
            6'h23: begin
                pushCycle(4'd5, op, 1'b0);
                for (int i = 0; i < memWaits; i++) pushCycle(4'd6, op, 1'b0);
                pushCycle(4'd6, op, 1'b1);
                pushCycle(4'd8, op, 1'b0);
            end
            6'h2B: begin
                pushCycle(4'd5, op, 1'b1);
                for (int i = 0; i < memWaits; i++) pushCycle(4'd7, op, 1'b0);
                pushCycle(4'd7, op, 1'b1);
            end
            6'h04, 6'h05: pushCycle(4'd9, op, 1'($urandom_range(0, 1)));
            6'h02:        pushCycle(4'd10, op, 1'($urandom_range(0, 1)));
            default: begin pushCycle(4'd11, op, 1'b1); retires = 1'b0; end
        endcase
        if (retires) cntModel = cntModel + 2'd1;
    endtask

    // Drive each queued cycle's inputs at the falling edge and compare just after.
    task automatic drain();
        cycleT e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            OP = e.op;
            memReady = e.rdy;
            #1;
            checkVal("state", 32'(stateO), 32'(e.st));
            checkVal("ctrl", 32'(ctrlObs), 32'(e.ctrl));
            checkVal("illegal_op", 32'(illegalOp), 32'(e.ill));
            checkVal("retired_cnt", 32'(retiredCnt), 32'(e.cnt));
            @(negedge clk);
        end
    endtask

    logic [3:0] swStates [5];

    initial begin
        reset = 1'b1; memReady = 1'b1; OP = 6'h00;
        reset2 = 1'b1; memReady2 = 1'b0; op2 = 6'h2B;

        // Reset values, checked before any clock edge.
        #3;
        checkVal("rst_state", 32'(stateO), 32'd0);
        checkVal("rst_cnt", 32'(retiredCnt), 32'd0);
        checkVal("rst_pcwrite", 32'(PCWrite), 32'd0);
        checkVal("rst_irwrite", 32'(IRWrite), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Full instruction mix: R, I-types (wrap at 4th retire), LW/SW with waits,
        // branches, jump, illegal opcodes, then R-type to show the count held.
        pushInstr(6'h00, 0, 0);
        pushInstr(6'h08, 1, 0);
        pushInstr(6'h0D, 0, 0);
        pushInstr(6'h0C, 0, 0);
        pushInstr(6'h0F, 0, 0);
        pushInstr(6'h23, 0, 2);
        pushInstr(6'h2B, 2, 1);
        pushInstr(6'h05, 0, 0);
        pushInstr(6'h04, 0, 0);
        pushInstr(6'h02, 0, 0);
        pushInstr(6'h3F, 0, 0);
        pushInstr(6'h01, 0, 0);
        pushInstr(6'h23, 0, 0);
        pushInstr(6'h00, 0, 0);
        drain();

        // Park an SW in its MEM_WR wait, then hit reset between clock edges.
        pushCycle(4'd0, 6'h2B, 1'b1);
        pushCycle(4'd1, 6'h2B, 1'b1);
        pushCycle(4'd5, 6'h2B, 1'b0);
        pushCycle(4'd7, 6'h2B, 1'b0);
        pushCycle(4'd7, 6'h2B, 1'b0);
        drain();
        #2;
        memReady = 1'b1;
        reset = 1'b1;
        #1;
        checkVal("async_state", 32'(stateO), 32'd0);
        checkVal("async_memwrite", 32'(MemWrite), 32'd0);
        checkVal("async_cnt", 32'(retiredCnt), 32'd0);
        checkVal("async_pcwrite", 32'(PCWrite), 32'd0);
        checkVal("async_irwrite", 32'(IRWrite), 32'd0);
        @(negedge clk);
        checkVal("hold_state", 32'(stateO), 32'd0);
        reset = 1'b0;
        cntModel = 2'd0;
        pushInstr(6'h2B, 0, 0);
        pushInstr(6'h00, 0, 0);
        drain();

        // MEM_WAIT=0 instance: SW must not stall although mem_ready stays low.
        swStates = '{4'd0, 4'd1, 4'd5, 4'd7, 4'd0};
        reset2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkVal("nowait_state", 32'(stateO2), 32'(swStates[i]));
            if (i == 0) checkVal("nowait_irwrite", 32'(IRWrite2), 32'd1);
            if (i == 3) checkVal("nowait_memwrite", 32'(MemWrite2), 32'd1);
            @(negedge clk);
        end
        checkVal("nowait_cnt", 32'(retiredCnt2), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
